// File: rtl/uart_frame_decoder.sv
// Strips start/escape/end framing from UART bytes and holds one frame for a valid/ready consumer.
// Optional UART_FRAME_CHECKSUM_EN: the last buffered byte is a mod-256 zero-sum checksum; bytes arriving in HOLD are dropped and counted.
module uart_frame_decoder #(
  parameter int         MAX_LEN    = 6,
  parameter int         MIN_LEN    = 1,
  parameter logic [7:0] START_CHAR = 8'h01,
  parameter logic [7:0] END_CHAR   = 8'h03,
  parameter logic [7:0] ESC_CHAR   = 8'h02,
  parameter int         LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk_12MHz,
  input  logic                 reset,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  output logic [8*MAX_LEN-1:0] frame_data,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [7:0]           err_count,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, RECEIVE, ESCAPED, HOLD} state_t;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int MIN_CNT = MIN_LEN + 1;
`else
  localparam int MIN_CNT = MIN_LEN;
`endif
  localparam logic [LEN_W:0]   MIN_CNT_W = (LEN_W + 1)'(MIN_CNT);
  localparam logic [LEN_W-1:0] MAX_CNT   = LEN_W'(MAX_LEN);

  state_t               state, state_n;
  logic [LEN_W-1:0]     count, count_n;
  logic [8*MAX_LEN-1:0] data_n;
  logic [LEN_W-1:0]     len_n;
  logic                 err_inc;
  logic                 deposit;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]           sum, sum_n;
`endif

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      frame_data <= '0;
      frame_len  <= '0;
      err_count  <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state      <= state_n;
      count      <= count_n;
      frame_data <= data_n;
      frame_len  <= len_n;
      if (err_inc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
`ifdef UART_FRAME_CHECKSUM_EN
      sum        <= sum_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    data_n  = frame_data;
    len_n   = frame_len;
    err_inc = 1'b0;
    deposit = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    sum_n   = sum;
`endif

    case (state)
      IDLE: begin
        if (rx_valid && rx_byte == START_CHAR) begin
          state_n = RECEIVE;
          count_n = '0;
`ifdef UART_FRAME_CHECKSUM_EN
          sum_n   = '0;
`endif
        end
      end

      RECEIVE: begin
        if (rx_valid) begin
          if (rx_byte == START_CHAR) begin
            count_n = '0;
            err_inc = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_n   = '0;
`endif
          end else if (rx_byte == ESC_CHAR) begin
            state_n = ESCAPED;
          end else if (rx_byte == END_CHAR) begin
`ifdef UART_FRAME_CHECKSUM_EN
            if ({1'b0, count} >= MIN_CNT_W && sum == 8'h00) begin
              state_n = HOLD;
              len_n   = count - LEN_W'(1);
            end else begin
              state_n = IDLE;
              err_inc = 1'b1;
            end
`else
            if ({1'b0, count} >= MIN_CNT_W) begin
              state_n = HOLD;
              len_n   = count;
            end else begin
              state_n = IDLE;
              err_inc = 1'b1;
            end
`endif
          end else begin
            deposit = 1'b1;
          end
        end
      end

      ESCAPED: begin
        if (rx_valid) begin
          state_n = RECEIVE;
          deposit = 1'b1;
        end
      end

      HOLD: begin
        if (rx_valid)
          err_inc = 1'b1;
        if (frame_ready)
          state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Shared store path for plain and escaped bytes; a full buffer aborts the frame.
    if (deposit) begin
      if (count == MAX_CNT) begin
        state_n = IDLE;
        err_inc = 1'b1;
      end else begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (count == LEN_W'(i))
            data_n[8*i +: 8] = rx_byte;
        end
        count_n = count + LEN_W'(1);
`ifdef UART_FRAME_CHECKSUM_EN
        sum_n   = sum + rx_byte;
`endif
      end
    end
  end

  assign frame_valid = (state == HOLD);
  assign busy        = (state == RECEIVE) || (state == ESCAPED);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: stimulus queues expected frames, a monitor checks each presented frame.
module tb_uart_frame_decoder;

  logic        clk_12MHz = 1'b0;
  logic        reset     = 1'b1;
  logic [7:0]  rx_byte   = 8'h00;
  logic        rx_valid  = 1'b0;
  logic [47:0] frame_data;
  logic [2:0]  frame_len;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [7:0]  err_count;
  logic        busy;

  uart_frame_decoder dut (
    .clk_12MHz  (clk_12MHz),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_data (frame_data),
    .frame_len  (frame_len),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #41 clk_12MHz = ~clk_12MHz;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int exp_err  = 0;

  typedef struct {
    int          len;
    logic [47:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk_12MHz);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++)
      send(v[8*(n-1-i) +: 8]);
  endtask

  // Called just after the END byte is taken: the frame must appear at the next negedge.
  task automatic expect_frame(input int len, input logic [47:0] data);
    exp_t e;
    e.len  = len;
    e.data = data;
    e.cyc  = ncyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!frame_valid && n < 20) begin
      @(negedge clk_12MHz);
      n++;
    end
    check("frame_valid_wait", 64'(frame_valid), 64'd1);
  endtask

  task automatic consume(input bit with_byte);
    @(posedge clk_12MHz);
    #1;
    frame_ready = 1'b1;
    if (with_byte) begin
      rx_byte  = 8'hEE;
      rx_valid = 1'b1;
    end
    @(posedge clk_12MHz);
    #1;
    frame_ready = 1'b0;
    rx_valid    = 1'b0;
    check("valid_after_ready", 64'(frame_valid), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 64'(frame_valid), 64'd0);
    check({tag, "_len"},   64'(frame_len),   64'd0);
    check({tag, "_data"},  64'(frame_data),  64'd0);
    check({tag, "_err"},   64'(err_count),   64'd0);
    check({tag, "_busy"},  64'(busy),        64'd0);
  endtask

  logic fv_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk_12MHz) begin
    ncyc++;
    if (frame_valid && !fv_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got frame of len %0d, expected none", frame_len);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_len", 64'(frame_len), 64'(mon_e.len));
        for (int i = 0; i < mon_e.len; i++)
          check("frame_byte", 64'(frame_data[8*i +: 8]), 64'(mon_e.data[8*i +: 8]));
        check("frame_latency", 64'(ncyc), 64'(mon_e.cyc));
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk_12MHz);
    #1;
    reset = 1'b0;
    check_reset("reset");

`ifdef UART_FRAME_CHECKSUM_EN
    send_bytes(64'h01_10_20_D0_03, 5);
    expect_frame(2, 48'h2010);
    wait_valid();
    consume(1'b0);
    check("err_cksum_ok", 64'(err_count), 64'd0);

    send_bytes(64'h01_10_20_D1_03, 5);
    repeat (3) @(posedge clk_12MHz);
    #1;
    check("valid_cksum_bad", 64'(frame_valid), 64'd0);
    check("err_cksum_bad", 64'(err_count), 64'd1);
`else
    // Basic frame with delayed ready
    send_bytes(64'h01_41_42, 3);
    check("busy_rx", 64'(busy), 64'd1);
    send(8'h03);
    expect_frame(2, 48'h4241);
    wait_valid();
    repeat (3) @(posedge clk_12MHz);
    #1;
    check("hold_valid", 64'(frame_valid), 64'd1);
    check("hold_data", 64'(frame_data[15:0]), 64'h4241);
    consume(1'b0);
    check("err_basic", 64'(err_count), 64'd0);

    // Escaped control characters stored literally
    send_bytes(64'h01_02_03_02_01_44_03, 7);
    expect_frame(3, 48'h440103);
    wait_valid();
    consume(1'b0);
    check("err_escape", 64'(err_count), 64'd0);

    // Overflow: seventh data byte aborts, trailing END in IDLE is ignored
    send_bytes(64'h01_10_11_12_13_14_15_16, 8);
    send(8'h03);
    exp_err = 1;
    check("err_overflow", 64'(err_count), 64'(exp_err));
    check("busy_overflow", 64'(busy), 64'd0);
    check("valid_overflow", 64'(frame_valid), 64'd0);
    send_bytes(64'h01_55_03, 3);
    expect_frame(1, 48'h55);
    wait_valid();
    consume(1'b0);

    // Restart mid-frame, byte dropped on handshake cycle, then short frame
    send_bytes(64'h01_11_01_22_03, 5);
    expect_frame(1, 48'h22);
    exp_err = 2;
    check("err_restart", 64'(err_count), 64'(exp_err));
    wait_valid();
    consume(1'b1);
    exp_err = 3;
    check("err_handshake_drop", 64'(err_count), 64'(exp_err));
    send_bytes(64'h01_03, 2);
    exp_err = 4;
    check("err_short", 64'(err_count), 64'(exp_err));
    check("valid_short", 64'(frame_valid), 64'd0);

    // Drops in HOLD saturate the error counter
    send_bytes(64'h01_77_03, 3);
    expect_frame(1, 48'h77);
    wait_valid();
    @(posedge clk_12MHz);
    #1;
    for (int i = 0; i < 300; i++)
      send(8'(i));
    check("sat_data", 64'(frame_data[7:0]), 64'h77);
    check("sat_len", 64'(frame_len), 64'd1);
    check("sat_err", 64'(err_count), 64'hFF);
    consume(1'b0);
`endif

    // Reset mid-frame
    send_bytes(64'h01_33_44, 3);
    check("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk_12MHz);
    #1;
    check_reset("midreset");
    reset = 1'b0;
    repeat (2) @(posedge clk_12MHz);
    #1;

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Parametrised successor to the Uniboard command-frame receiver.
- Consumes bytes from the UART receiver and strips start, escape and end framing. Buffers up to MAX_LEN payload bytes and presents each complete frame to the command processor through a valid/ready handshake.
- Counts malformed and dropped frames for the status register.

Parameters:
- MAX_LEN, 6, payload buffer depth in bytes (1..32).
- MIN_LEN, 1, minimum accepted payload length in bytes (0..MAX_LEN).
- START_CHAR, 8'h01, frame start byte.
- END_CHAR, 8'h03, frame end byte.
- ESC_CHAR, 8'h02, escape byte; the next byte is stored literally.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.

Ports:
- clk_12MHz  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_byte  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  single-cycle strobe, one per received byte.
- frame_data  output  8*MAX_LEN  payload bytes; byte i sits at bits [8i+7:8i]; byte 0 is the first received.
- frame_len  output  LEN_W  payload length of the held frame.
- frame_valid  output  1  a complete frame is held.
- frame_ready  input  1  consumer accepts the frame when high together with frame_valid.
- err_count  output  8  saturating count of rejected frames and dropped bytes.
- busy  output  1  high in RECEIVE or ESCAPED.

Behaviour:
- Clock and reset: clk_12MHz; reset synchronous, active-high.
- Reset values: state=IDLE, count=0, frame_valid=0, frame_len=0, frame_data=0, err_count=0, busy=0.
- Only cycles with rx_valid=1 advance framing. All transitions are registered; frame_valid rises the cycle after the END_CHAR strobe.
- IDLE:
  - START_CHAR -> RECEIVE, count=0.
  - Any other byte is ignored (not counted as an error).
- RECEIVE:
  - START_CHAR -> discard partial frame, count=0, stay in RECEIVE; err_count += 1.
  - ESC_CHAR -> ESCAPED.
  - END_CHAR with count>=MIN_LEN -> HOLD; frame_len=count, frame_valid=1.
  - END_CHAR with count<MIN_LEN -> IDLE; err_count += 1.
  - Any other byte with count<MAX_LEN -> buffer[count]=byte, count += 1.
  - Any other byte with count==MAX_LEN (overflow) -> IDLE, frame discarded, err_count += 1.
- ESCAPED:
  - Any byte, including START, END or ESC, is deposited literally under the same overflow rule, then -> RECEIVE.
- HOLD:
  - frame_data and frame_len stay stable.
  - frame_valid & frame_ready -> IDLE next cycle, frame_valid=0.
  - Any rx_valid byte while in HOLD, including the handshake cycle, is dropped; err_count += 1.
- err_count saturates at 8'hFF and never wraps.
- Simultaneous events in one cycle cost one err_count increment per event, still saturating.
- Buffer entries at and above frame_len hold stale data; consumers use only frame_len bytes.
- Reset asserted mid-frame or in HOLD returns every register to its reset value on the next edge.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- Defined:
  - The last buffered byte is a checksum. The 8-bit modulo-256 sum of all buffered bytes, including the checksum, must equal 8'h00.
  - On END_CHAR the sum is checked. Mismatch -> IDLE, err_count += 1.
  - Match -> HOLD with frame_len=count-1.
  - Minimum buffered count is MIN_LEN+1; the payload limit is MAX_LEN-1 data bytes plus the checksum.
  - The running sum is accumulated per deposited byte, so there is no added latency.
- Undefined: no checksum logic; frame_len=count.

Test Plan:
- Basic frame: rx 01 41 42 03, frame_ready=0 -> frame_valid=1 one cycle after the 03 strobe; frame_len=2; frame_data[15:0]=16'h4241. Then pulse ready -> frame_valid=0 next cycle.
- Escaping: rx 01 02 03 02 01 44 03 -> frame_len=3, bytes 03 01 44, err_count=0.
- Overflow with MAX_LEN=6: rx 01, then 7 data bytes, then 03 -> no frame_valid, err_count=1; subsequent 01 55 03 is accepted with frame_len=1.
- Restart and short frame with MIN_LEN=1: rx 01 11 01 22 03 -> frame_len=1, byte 22, err_count=1. Then rx 01 03 -> no frame, err_count=2.
- HOLD drop and saturation: hold a frame, send 300 bytes -> frame data unchanged, err_count=8'hFF. Assert reset mid-frame -> all outputs return to reset values.
- Checksum (UART_FRAME_CHECKSUM_EN): rx 01 10 20 D0 03 -> frame_len=2. rx 01 10 20 D1 03 -> rejected, err_count += 1.
